// File: rtl/branch_update_scheduler.sv
// Branch update scheduler: a 2-bit pattern-history table that takes one lookup
// or one drained update per cycle. Resolved branches from the execute and parse
// stages queue in a small FIFO. A starvation limit makes sure updates drain
// even while fetch keeps looking up.
module branch_update_scheduler #(
   parameter int         ENTRIES      = 16,
   parameter int         FIFO_DEPTH   = 4,
   parameter logic [1:0] INIT_STATE   = 2'b01,
   parameter int         STARVE_LIMIT = 3
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush,
   input  logic                          lookup_valid,
   input  logic [39:0]                   lookup_addr,
   output logic                          lookup_ready,
   output logic                          pred_valid,
   output logic                          pred_taken,
   input  logic                          upd_ex_valid,
   input  logic [39:0]                   upd_ex_addr,
   input  logic                          upd_ex_taken,
   input  logic                          upd_an_valid,
   input  logic [39:0]                   upd_an_addr,
   input  logic                          upd_an_taken,
   output logic                          upd_drop,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

   typedef enum logic {INIT, RUN} state_t;

   state_t             state, stateNext;
   logic [IDX_W-1:0]   initIdx;
   logic [1:0]         phtTable [ENTRIES];
   logic [IDX_W-1:0]   fifoIdx [FIFO_DEPTH];
   logic               fifoTaken [FIFO_DEPTH];
   logic [PTR_W-1:0]   headPtr, tailPtr, anSlot;
   logic [CNT_W-1:0]   fifoCount;
   logic [CNT_W:0]     freeSlots;
   logic [STV_W-1:0]   starveCnt;
   logic               runActive, initWrite, fifoEmpty, fifoFull;
   logic               doDrain, doLookup, acceptEx, acceptAn;
   logic [1:0]         headCtr, headNext;
   logic [IDX_W-1:0]   lookupIdx, exIdx, anIdx, headIdx;
   logic               unusedAddrBits;

   assign lookupIdx = lookup_addr[IDX_W+1:2];
   assign exIdx     = upd_ex_addr[IDX_W+1:2];
   assign anIdx     = upd_an_addr[IDX_W+1:2];
   assign unusedAddrBits = ^{lookup_addr[39:IDX_W+2], lookup_addr[1:0],
                             upd_ex_addr[39:IDX_W+2], upd_ex_addr[1:0],
                             upd_an_addr[39:IDX_W+2], upd_an_addr[1:0]};

   function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
      if (int'(p) == FIFO_DEPTH - 1) return '0;
      return p + 1'b1;
   endfunction

   // Arbitration, enqueue decisions and the saturating counter update for the FIFO head.
   // NOTE: every signal gets a default at the top so no path through this block infers a latch.
   always_comb begin
      stateNext = state;
      doDrain   = 1'b0;
      doLookup  = 1'b0;
      acceptEx  = 1'b0;
      acceptAn  = 1'b0;
      anSlot    = tailPtr;
      runActive = !rst && !flush && (state == RUN);
      initWrite = !rst && !flush && (state == INIT);
      fifoEmpty = (fifoCount == '0);
      fifoFull  = (fifoCount == CNT_W'(FIFO_DEPTH));
      headIdx   = fifoIdx[headPtr];
      headCtr   = phtTable[headIdx];
      headNext  = headCtr;
      if (fifoTaken[headPtr]) begin
         if (headCtr != 2'b11) headNext = headCtr + 2'b01;
      end else begin
         if (headCtr != 2'b00) headNext = headCtr - 2'b01;
      end
      if (initWrite && initIdx == IDX_W'(ENTRIES - 1)) stateNext = RUN;
      if (runActive) begin
         doDrain  = !fifoEmpty &&
                    (fifoFull || !lookup_valid || starveCnt == STV_W'(STARVE_LIMIT));
         doLookup = lookup_valid && !doDrain;
      end
      freeSlots = (CNT_W+1)'(FIFO_DEPTH) - {1'b0, fifoCount} + {{CNT_W{1'b0}}, doDrain};
      acceptEx  = runActive && upd_ex_valid && (freeSlots != '0);
      acceptAn  = runActive && upd_an_valid && (freeSlots > {{CNT_W{1'b0}}, acceptEx});
      if (acceptEx) anSlot = ptrInc(tailPtr);
   end

   assign lookup_ready = doLookup;
   assign upd_drop     = runActive && ((upd_ex_valid && !acceptEx) || (upd_an_valid && !acceptAn));
   assign busy         = (state == INIT);
   assign fifo_count   = fifoCount;

   // Control state: FSM, init walk, FIFO pointers, starvation counter, prediction register.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         state      <= INIT;
         initIdx    <= '0;
         headPtr    <= '0;
         tailPtr    <= '0;
         fifoCount  <= '0;
         starveCnt  <= '0;
         pred_valid <= 1'b0;
         pred_taken <= 1'b0;
      end else begin
         state      <= stateNext;
         if (state == INIT) initIdx <= initIdx + 1'b1;
         if (doDrain) headPtr <= ptrInc(headPtr);
         if (acceptEx && acceptAn) tailPtr <= ptrInc(ptrInc(tailPtr));
         else if (acceptEx || acceptAn) tailPtr <= ptrInc(tailPtr);
         fifoCount  <= fifoCount + CNT_W'(acceptEx) + CNT_W'(acceptAn) - CNT_W'(doDrain);
         if (doDrain || fifoEmpty) starveCnt <= '0;
         else if (doLookup) starveCnt <= starveCnt + 1'b1;
         pred_valid <= doLookup;
         pred_taken <= doLookup && phtTable[lookupIdx][1];
      end
   end

   // Table and FIFO payload storage.
   // NOTE: storage arrays are not reset; the table is filled by the INIT walk and FIFO slots are
   // only read once written.
   always_ff @(posedge clk) begin
      if (initWrite) phtTable[initIdx] <= INIT_STATE;
      else if (doDrain) phtTable[headIdx] <= headNext;
      if (acceptEx) begin
         fifoIdx[tailPtr]   <= exIdx;
         fifoTaken[tailPtr] <= upd_ex_taken;
      end
      if (acceptAn) begin
         fifoIdx[anSlot]   <= anIdx;
         fifoTaken[anSlot] <= upd_an_taken;
      end
   end

endmodule

// File: tb/tb_branch_update_scheduler.sv
// Self-checking bench: directed vector table, hand sequences for flush/init,
// and random traffic checked against a queue-based reference model.
module tb_branch_update_scheduler;

   localparam int ENTRIES      = 16;
   localparam int FIFO_DEPTH   = 4;
   localparam int STARVE_LIMIT = 3;
   localparam int INIT_VAL     = 1;

   logic        clk = 1'b0;
   logic        rst, flush, lookup_valid, lookup_ready, pred_valid, pred_taken;
   logic [39:0] lookup_addr, upd_ex_addr, upd_an_addr;
   logic        upd_ex_valid, upd_ex_taken, upd_an_valid, upd_an_taken, upd_drop, busy;
   logic [2:0]  fifo_count;

   branch_update_scheduler dut (
      .clk(clk), .rst(rst), .flush(flush),
      .lookup_valid(lookup_valid), .lookup_addr(lookup_addr), .lookup_ready(lookup_ready),
      .pred_valid(pred_valid), .pred_taken(pred_taken),
      .upd_ex_valid(upd_ex_valid), .upd_ex_addr(upd_ex_addr), .upd_ex_taken(upd_ex_taken),
      .upd_an_valid(upd_an_valid), .upd_an_addr(upd_an_addr), .upd_an_taken(upd_an_taken),
      .upd_drop(upd_drop), .busy(busy), .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference model: counter table, update queue, starvation count, init progress.
   typedef struct { int idx; bit taken; } upd_t;
   int   mTable [ENTRIES];
   upd_t mQ [$];
   int   mStarve, mInitIdx;
   bit   mInit, mPredV, mPredT;

   // Values sampled mid-cycle by cycle(), for the vector table to compare.
   bit sLr, sDrop, sPv, sPt;
   int sCnt;

   function automatic int idxOf(input logic [39:0] a);
      return int'((a >> 2) & 40'(ENTRIES - 1));
   endfunction

   task automatic modelReset();
      mQ.delete();
      mStarve = 0; mInit = 1; mInitIdx = 0; mPredV = 0; mPredT = 0;
   endtask

   // Drive one cycle of inputs, compare all outputs with the model, advance the model.
   task automatic cycle(input bit lv, input logic [39:0] la,
                        input bit ev, input logic [39:0] ea, input bit et,
                        input bit av, input logic [39:0] aa, input bit at,
                        input bit fl);
      bit eLr, eDrop, drain, lookup;
      int n, space;
      upd_t u;
      lookup_valid = lv; lookup_addr = la;
      upd_ex_valid = ev; upd_ex_addr = ea; upd_ex_taken = et;
      upd_an_valid = av; upd_an_addr = aa; upd_an_taken = at;
      flush = fl;
      #4;
      n = mQ.size();
      drain = 0; lookup = 0; eDrop = 0; space = 0;
      if (!fl && !mInit) begin
         drain  = (n > 0) && (n == FIFO_DEPTH || !lv || mStarve == STARVE_LIMIT);
         lookup = lv && !drain;
         space  = FIFO_DEPTH - n + (drain ? 1 : 0);
         eDrop  = (ev && space < 1) || (av && space < (ev ? 2 : 1));
      end
      eLr = lookup;
      sLr = lookup_ready; sDrop = upd_drop; sPv = pred_valid; sPt = pred_taken;
      sCnt = int'(fifo_count);
      check("lookup_ready", lookup_ready, eLr);
      check("upd_drop", upd_drop, eDrop);
      check("busy", busy, mInit);
      check("fifo_count", fifo_count, n);
      check("pred_valid", pred_valid, mPredV);
      check("pred_taken", pred_taken, mPredT);
      if (fl) begin
         modelReset();
      end else if (mInit) begin
         mTable[mInitIdx] = INIT_VAL;
         mInitIdx++;
         if (mInitIdx == ENTRIES) mInit = 0;
         mPredV = 0; mPredT = 0;
      end else begin
         mPredV = lookup;
         mPredT = lookup && (mTable[idxOf(la)] >= 2);
         if (drain) begin
            u = mQ.pop_front();
            if (u.taken) mTable[u.idx] = (mTable[u.idx] == 3) ? 3 : mTable[u.idx] + 1;
            else         mTable[u.idx] = (mTable[u.idx] == 0) ? 0 : mTable[u.idx] - 1;
         end
         if (drain || n == 0) mStarve = 0;
         else if (lookup) mStarve++;
         if (ev && space >= 1) begin mQ.push_back('{idxOf(ea), et}); space--; end
         if (av && space >= 1) mQ.push_back('{idxOf(aa), at});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cycle(0, '0, 0, '0, 0, 0, '0, 0, 0);
   endtask

   // Run idle cycles while the DUT is initialising, bounded; returns cycles spent busy.
   task automatic waitInit(output int n);
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         idle();
         n++;
      end
   endtask

   typedef struct {
      bit lv; logic [39:0] la;
      bit ev; logic [39:0] ea; bit et;
      bit av; logic [39:0] aa; bit at;
      bit lr; bit drop; bit pv; bit pt; int cnt;
   } vec_t;

   vec_t vecs [25];

   function automatic vec_t mk(input bit lv, input logic [39:0] la,
                               input bit ev, input logic [39:0] ea,
                               input bit av, input logic [39:0] aa,
                               input bit lr, input bit drop, input bit pv, input bit pt,
                               input int cnt);
      vec_t v;
      v.lv = lv; v.la = la; v.ev = ev; v.ea = ea; v.et = 1'b1;
      v.av = av; v.aa = aa; v.at = 1'b1;
      v.lr = lr; v.drop = drop; v.pv = pv; v.pt = pt; v.cnt = cnt;
      return v;
   endfunction

   initial begin
      int n;
      logic [39:0] ra, rb, rc;

      vecs[0]  = mk(1, 40'h100, 0, 0,      0, 0,      1, 0, 0, 0, 0);
      vecs[1]  = mk(0, 0,       0, 0,      0, 0,      0, 0, 1, 0, 0);
      vecs[2]  = mk(0, 0,       1, 40'h104, 0, 0,     0, 0, 0, 0, 0);
      vecs[3]  = mk(0, 0,       0, 0,      0, 0,      0, 0, 0, 0, 1);
      vecs[4]  = mk(0, 0,       1, 40'h104, 0, 0,     0, 0, 0, 0, 0);
      vecs[5]  = mk(0, 0,       0, 0,      0, 0,      0, 0, 0, 0, 1);
      vecs[6]  = mk(0, 0,       1, 40'h104, 0, 0,     0, 0, 0, 0, 0);
      vecs[7]  = mk(0, 0,       0, 0,      0, 0,      0, 0, 0, 0, 1);
      vecs[8]  = mk(1, 40'h104, 0, 0,      0, 0,      1, 0, 0, 0, 0);
      vecs[9]  = mk(0, 0,       0, 0,      0, 0,      0, 0, 1, 1, 0);
      vecs[10] = mk(1, 40'h200, 1, 40'h108, 0, 0,     1, 0, 0, 0, 0);
      vecs[11] = mk(1, 40'h200, 1, 40'h10C, 0, 0,     1, 0, 1, 0, 1);
      vecs[12] = mk(1, 40'h200, 1, 40'h110, 0, 0,     1, 0, 1, 0, 2);
      vecs[13] = mk(1, 40'h200, 1, 40'h114, 1, 40'h118, 1, 1, 1, 0, 3);
      vecs[14] = mk(1, 40'h200, 0, 0,      0, 0,      0, 0, 1, 0, 4);
      vecs[15] = mk(0, 0,       0, 0,      0, 0,      0, 0, 0, 0, 3);
      vecs[16] = mk(0, 0,       0, 0,      0, 0,      0, 0, 0, 0, 2);
      vecs[17] = mk(0, 0,       0, 0,      0, 0,      0, 0, 0, 0, 1);
      vecs[18] = mk(0, 0,       1, 40'h120, 0, 0,     0, 0, 0, 0, 0);
      vecs[19] = mk(1, 40'h100, 0, 0,      0, 0,      1, 0, 0, 0, 1);
      vecs[20] = mk(1, 40'h100, 0, 0,      0, 0,      1, 0, 1, 0, 1);
      vecs[21] = mk(1, 40'h100, 0, 0,      0, 0,      1, 0, 1, 0, 1);
      vecs[22] = mk(1, 40'h100, 0, 0,      0, 0,      0, 0, 1, 0, 1);
      vecs[23] = mk(1, 40'h100, 0, 0,      0, 0,      1, 0, 0, 0, 0);
      vecs[24] = mk(0, 0,       0, 0,      0, 0,      0, 0, 1, 0, 0);

      // Reset with traffic present: outputs must stay quiet.
      rst = 1; flush = 0;
      lookup_valid = 1; lookup_addr = 40'h100;
      upd_ex_valid = 1; upd_ex_addr = 40'h104; upd_ex_taken = 1;
      upd_an_valid = 1; upd_an_addr = 40'h108; upd_an_taken = 0;
      @(posedge clk); #1;
      check("rst_lookup_ready", lookup_ready, 0);
      check("rst_upd_drop", upd_drop, 0);
      check("rst_busy", busy, 1);
      check("rst_fifo_count", fifo_count, 0);
      check("rst_pred_valid", pred_valid, 0);
      check("rst_pred_taken", pred_taken, 0);
      @(posedge clk); #1;
      rst = 0;
      modelReset();

      waitInit(n);
      check("reset_init_cycles", n, 16);

      // Directed vectors: lookups, saturation, fifo full/drop, starvation.
      for (int i = 0; i < 25; i++) begin
         cycle(vecs[i].lv, vecs[i].la, vecs[i].ev, vecs[i].ea, vecs[i].et,
               vecs[i].av, vecs[i].aa, vecs[i].at, 0);
         check($sformatf("vec%0d_lookup_ready", i), sLr, vecs[i].lr);
         check($sformatf("vec%0d_upd_drop", i), sDrop, vecs[i].drop);
         check($sformatf("vec%0d_pred_valid", i), sPv, vecs[i].pv);
         check($sformatf("vec%0d_pred_taken", i), sPt, vecs[i].pt);
         check($sformatf("vec%0d_fifo_count", i), sCnt, vecs[i].cnt);
         if (i == 7) check("ctr_0x104_saturated", dut.phtTable[1], 3);
      end

      // Flush with two updates pending, then again mid-INIT at index 7.
      cycle(1, 40'h300, 1, 40'h124, 1, 1, 40'h128, 0, 0);
      cycle(1, 40'h300, 0, '0, 0, 0, '0, 0, 1);
      check("flush_pending_count", sCnt, 2);
      check("flush_lookup_blocked", sLr, 0);
      check("after_flush_fifo_count", fifo_count, 0);
      check("after_flush_busy", busy, 1);
      check("after_flush_pred_valid", pred_valid, 0);
      for (int i = 0; i < 7; i++) idle();
      cycle(0, '0, 1, 40'h104, 1, 0, '0, 0, 1);
      waitInit(n);
      check("reflush_init_cycles", n, 16);

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         ra = {8'($urandom), 32'($urandom)};
         rb = {8'($urandom), 32'($urandom)};
         rc = {8'($urandom), 32'($urandom)};
         if ($urandom_range(0, 1) == 0) rb[39:6] = '0;
         cycle($urandom_range(0, 3) != 0, ra,
               $urandom_range(0, 2) == 0, rb, 1'($urandom),
               $urandom_range(0, 3) == 0, rc, 1'($urandom),
               $urandom_range(0, 299) == 0);
      end

      // Drain everything and compare the whole table with the model.
      n = 0;
      while ((busy === 1'b1 || fifo_count !== '0) && n < 200) begin
         idle();
         n++;
      end
      check("final_drain_bounded", n < 200, 1);
      for (int i = 0; i < ENTRIES; i++)
         check($sformatf("final_table_%0d", i), dut.phtTable[i], mTable[i]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
